// File: rtl/rs_station_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rs_station_pkg
// Description : Shared types and default sizes for the reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
package rs_station_pkg;

    localparam int RS_N     = 8;
    localparam int RS_TAG_W = 6;
    localparam int RS_OP_W  = 8;

    typedef logic [RS_TAG_W-1:0] tag_t;
    typedef logic [RS_OP_W-1:0]  op_t;

    typedef struct packed {
        logic valid;
        op_t  op;
        tag_t src1_tag;
        logic src1_rdy;
        tag_t src2_tag;
        logic src2_rdy;
        tag_t dest_tag;
    } rs_entry_t;

    function automatic logic tag_match(input logic cdb_valid, input tag_t cdb_tag, input tag_t tag);
        return cdb_valid && (cdb_tag == tag);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pselect_RS.sv
`default_nettype none
// ============================================================================
// Module      : pselect_RS
// Description : Rotating-priority selector. Scans requests starting at i_sel,
//               upward (DIR=0) or downward (DIR=1), wrapping modulo N.
// Revision    : 1.0 - initial release
// ============================================================================
module pselect_RS #(
    parameter int N   = 8,
    parameter bit DIR = 1'b0
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_sel,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);

    localparam int c_IDX_W = $clog2(N);

    logic [c_IDX_W-1:0] w_cand;

    always_comb begin
        o_idx  = '0;
        o_any  = 1'b0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            // N is a power of two, so the index wraps naturally
            w_cand = DIR ? (i_sel - c_IDX_W'(k)) : (i_sel + c_IDX_W'(k));
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rs_entry.sv
`default_nettype none
// ============================================================================
// Module      : rs_entry
// Description : One reservation-station slot: load, CDB wakeup, clear, ready.
//               RS_WAKEUP_BYPASS_EN lets a same-cycle CDB match count as ready.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_entry
    import rs_station_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      i_load,
    input  rs_entry_t i_load_data,
    input  logic      i_clear,
    input  logic      i_cdb_valid,
    input  tag_t      i_cdb_tag,
    output logic      o_valid,
    output logic      o_ready,
    output op_t       o_op,
    output tag_t      o_src1_tag,
    output tag_t      o_src2_tag,
    output tag_t      o_dest_tag
);

    rs_entry_t r_entry;
    rs_entry_t w_next;
    logic      w_m1;
    logic      w_m2;

    assign w_m1 = tag_match(i_cdb_valid, i_cdb_tag, r_entry.src1_tag);
    assign w_m2 = tag_match(i_cdb_valid, i_cdb_tag, r_entry.src2_tag);

    always_comb begin
        w_next = r_entry;
        if (i_load) begin
            // a broadcast in the dispatch cycle must not be lost
            w_next          = i_load_data;
            w_next.src1_rdy = i_load_data.src1_rdy |
                              tag_match(i_cdb_valid, i_cdb_tag, i_load_data.src1_tag);
            w_next.src2_rdy = i_load_data.src2_rdy |
                              tag_match(i_cdb_valid, i_cdb_tag, i_load_data.src2_tag);
        end else if (i_clear) begin
            w_next.valid = 1'b0;
        end else if (r_entry.valid) begin
            w_next.src1_rdy = r_entry.src1_rdy | w_m1;
            w_next.src2_rdy = r_entry.src2_rdy | w_m2;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_entry <= '0;
        end else begin
            r_entry <= w_next;
        end
    end

`ifdef RS_WAKEUP_BYPASS_EN
    assign o_ready = r_entry.valid && (r_entry.src1_rdy || w_m1) && (r_entry.src2_rdy || w_m2);
`else
    assign o_ready = r_entry.valid && r_entry.src1_rdy && r_entry.src2_rdy;
`endif

    assign o_valid    = r_entry.valid;
    assign o_op       = r_entry.op;
    assign o_src1_tag = r_entry.src1_tag;
    assign o_src2_tag = r_entry.src2_tag;
    assign o_dest_tag = r_entry.dest_tag;

endmodule
`default_nettype wire

// File: rtl/rs_station.sv
`default_nettype none
// ============================================================================
// Module      : rs_station
// Description : N-entry reservation station with lowest-free allocation and
//               rotating-priority issue. Optional macro: RS_WAKEUP_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_station
    import rs_station_pkg::*;
#(
    parameter int N     = RS_N,
    parameter int TAG_W = RS_TAG_W,
    parameter int OP_W  = RS_OP_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              disp_valid,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [TAG_W-1:0]  disp_src1_tag,
    input  logic [TAG_W-1:0]  disp_src2_tag,
    input  logic              disp_src1_rdy,
    input  logic              disp_src2_rdy,
    input  logic [TAG_W-1:0]  disp_dest_tag,
    output logic              disp_ready,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [OP_W-1:0]   iss_op,
    output logic [TAG_W-1:0]  iss_src1_tag,
    output logic [TAG_W-1:0]  iss_src2_tag,
    output logic [TAG_W-1:0]  iss_dest_tag,
    output logic [$clog2(N):0] free_count
);

    localparam int c_IDX_W = $clog2(N);
    localparam int c_FC_W  = $clog2(N) + 1;

    logic [N-1:0]         w_valid;
    logic [N-1:0]         w_ready;
    logic [N-1:0]         w_load;
    logic [N-1:0]         w_clear;
    logic [c_IDX_W-1:0]   w_alloc_idx;
    logic                 w_alloc_any;
    logic [c_IDX_W-1:0]   w_iss_idx;
    logic                 w_iss_any;
    logic [c_IDX_W-1:0]   r_rot_sel;
    logic [c_FC_W-1:0]    r_free_count;
    logic                 w_disp_fire;
    logic                 w_iss_fire;
    rs_entry_t            w_disp_entry;

    logic [OP_W-1:0]      w_op   [N];
    logic [TAG_W-1:0]     w_src1 [N];
    logic [TAG_W-1:0]     w_src2 [N];
    logic [TAG_W-1:0]     w_dest [N];

    assign disp_ready  = (r_free_count != '0);
    assign w_disp_fire = disp_valid && disp_ready && w_alloc_any;
    assign iss_valid   = w_iss_any;
    assign w_iss_fire  = w_iss_any && iss_ready;
    assign free_count  = r_free_count;

    always_comb begin
        w_disp_entry          = '0;
        w_disp_entry.valid    = 1'b1;
        w_disp_entry.op       = disp_op;
        w_disp_entry.src1_tag = disp_src1_tag;
        w_disp_entry.src1_rdy = disp_src1_rdy;
        w_disp_entry.src2_tag = disp_src2_tag;
        w_disp_entry.src2_rdy = disp_src2_rdy;
        w_disp_entry.dest_tag = disp_dest_tag;
    end

    pselect_RS #(.N(N), .DIR(1'b0)) u_alloc_sel (
        .i_req (~w_valid),
        .i_sel ('0),
        .o_idx (w_alloc_idx),
        .o_any (w_alloc_any)
    );

    pselect_RS #(.N(N), .DIR(1'b0)) u_issue_sel (
        .i_req (w_ready),
        .i_sel (r_rot_sel),
        .o_idx (w_iss_idx),
        .o_any (w_iss_any)
    );

    generate
        for (genvar i = 0; i < N; i++) begin : g_entry
            assign w_load[i]  = w_disp_fire && (w_alloc_idx == c_IDX_W'(i));
            assign w_clear[i] = w_iss_fire  && (w_iss_idx   == c_IDX_W'(i));

            rs_entry u_entry (
                .clock       (clock),
                .reset       (reset),
                .i_load      (w_load[i]),
                .i_load_data (w_disp_entry),
                .i_clear     (w_clear[i]),
                .i_cdb_valid (cdb_valid),
                .i_cdb_tag   (cdb_tag),
                .o_valid     (w_valid[i]),
                .o_ready     (w_ready[i]),
                .o_op        (w_op[i]),
                .o_src1_tag  (w_src1[i]),
                .o_src2_tag  (w_src2[i]),
                .o_dest_tag  (w_dest[i])
            );
        end
    endgenerate

    always_comb begin
        iss_op       = '0;
        iss_src1_tag = '0;
        iss_src2_tag = '0;
        iss_dest_tag = '0;
        if (w_iss_any) begin
            iss_op       = w_op[w_iss_idx];
            iss_src1_tag = w_src1[w_iss_idx];
            iss_src2_tag = w_src2[w_iss_idx];
            iss_dest_tag = w_dest[w_iss_idx];
        end
    end

    // a freed slot only shows up in free_count on the following cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_free_count <= c_FC_W'(N);
            r_rot_sel    <= '0;
        end else begin
            r_free_count <= r_free_count - c_FC_W'(w_disp_fire) + c_FC_W'(w_iss_fire);
            if (w_iss_fire) begin
                r_rot_sel <= w_iss_idx + c_IDX_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_station.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_station
// Description : Self-checking bench for rs_station with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_station;

    localparam int N = 8;

    logic       clock;
    logic       reset;
    logic       disp_valid;
    logic [7:0] disp_op;
    logic [5:0] disp_src1_tag;
    logic [5:0] disp_src2_tag;
    logic       disp_src1_rdy;
    logic       disp_src2_rdy;
    logic [5:0] disp_dest_tag;
    logic       disp_ready;
    logic       cdb_valid;
    logic [5:0] cdb_tag;
    logic       iss_valid;
    logic       iss_ready;
    logic [7:0] iss_op;
    logic [5:0] iss_src1_tag;
    logic [5:0] iss_src2_tag;
    logic [5:0] iss_dest_tag;
    logic [3:0] free_count;

    int n_assert = 0;
    int n_fail   = 0;

    rs_station #(.N(N), .TAG_W(6), .OP_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .disp_valid    (disp_valid),
        .disp_op       (disp_op),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_dest_tag (disp_dest_tag),
        .disp_ready    (disp_ready),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .iss_valid     (iss_valid),
        .iss_ready     (iss_ready),
        .iss_op        (iss_op),
        .iss_src1_tag  (iss_src1_tag),
        .iss_src2_tag  (iss_src2_tag),
        .iss_dest_tag  (iss_dest_tag),
        .free_count    (free_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a table of slots plus the rotation start point
    logic       m_v  [N];
    logic [7:0] m_op [N];
    logic [5:0] m_t1 [N];
    logic [5:0] m_t2 [N];
    logic [5:0] m_dst[N];
    logic       m_r1 [N];
    logic       m_r2 [N];
    int         m_rot;

    function automatic bit m_ready(input int i);
        bit r1;
        bit r2;
        r1 = m_r1[i];
        r2 = m_r2[i];
`ifdef RS_WAKEUP_BYPASS_EN
        if (cdb_valid && cdb_tag == m_t1[i]) r1 = 1'b1;
        if (cdb_valid && cdb_tag == m_t2[i]) r2 = 1'b1;
`endif
        return m_v[i] && r1 && r2;
    endfunction

    initial begin
        for (int i = 0; i < N; i++) m_v[i] = 1'b0;
        m_rot = 0;
    end

    initial begin
        int fc;
        int g;
        int slot;
        @(posedge clock);
        forever begin
            @(negedge clock);
            fc = 0;
            g  = -1;
            for (int i = 0; i < N; i++) if (!m_v[i]) fc++;
            for (int k = 0; k < N; k++) if (g < 0 && m_ready((m_rot + k) % N)) g = (m_rot + k) % N;
            chk("free_count", 32'(free_count), 32'(fc));
            chk("disp_ready", 32'(disp_ready), 32'(fc != 0));
            chk("iss_valid",  32'(iss_valid),  32'(g >= 0));
            chk("iss_op",     32'(iss_op),       (g >= 0) ? 32'(m_op[g])  : 32'd0);
            chk("iss_src1",   32'(iss_src1_tag), (g >= 0) ? 32'(m_t1[g])  : 32'd0);
            chk("iss_src2",   32'(iss_src2_tag), (g >= 0) ? 32'(m_t2[g])  : 32'd0);
            chk("iss_dest",   32'(iss_dest_tag), (g >= 0) ? 32'(m_dst[g]) : 32'd0);
            // advance the model to the state after the coming edge
            if (!reset) begin
                for (int i = 0; i < N; i++) m_v[i] = 1'b0;
                m_rot = 0;
            end else begin
                slot = -1;
                for (int i = N - 1; i >= 0; i--) if (!m_v[i]) slot = i;
                for (int i = 0; i < N; i++) begin
                    if (m_v[i] && cdb_valid && cdb_tag == m_t1[i]) m_r1[i] = 1'b1;
                    if (m_v[i] && cdb_valid && cdb_tag == m_t2[i]) m_r2[i] = 1'b1;
                end
                if (g >= 0 && iss_ready) begin
                    m_v[g] = 1'b0;
                    m_rot  = (g + 1) % N;
                end
                if (disp_valid && fc != 0) begin
                    m_v[slot]   = 1'b1;
                    m_op[slot]  = disp_op;
                    m_t1[slot]  = disp_src1_tag;
                    m_t2[slot]  = disp_src2_tag;
                    m_dst[slot] = disp_dest_tag;
                    m_r1[slot]  = disp_src1_rdy || (cdb_valid && cdb_tag == disp_src1_tag);
                    m_r2[slot]  = disp_src2_rdy || (cdb_valid && cdb_tag == disp_src2_tag);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_disp(input logic v, input logic [7:0] op, input logic [5:0] t1, input logic r1,
                            input logic [5:0] t2, input logic r2, input logic [5:0] dst);
        disp_valid    = v;
        disp_op       = op;
        disp_src1_tag = t1;
        disp_src1_rdy = r1;
        disp_src2_tag = t2;
        disp_src2_rdy = r2;
        disp_dest_tag = dst;
    endtask

    initial begin
        reset     = 1'b0;
        iss_ready = 1'b0;
        cdb_valid = 1'b0;
        cdb_tag   = '0;
        set_disp(1'b1, 8'hAA, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3);

        // reset held low while dispatching
        repeat (3) step();
        chk("rst_free_count", 32'(free_count), 32'd8);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_iss_valid",  32'(iss_valid),  32'd0);
        reset = 1'b1;
        set_disp(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        step();

        // fill, overflow attempt, then drain in index order
        for (int i = 0; i < N; i++) begin
            set_disp(1'b1, 8'(8'h10 + i), 6'(i), 1'b1, 6'(i), 1'b1, 6'(i));
            step();
        end
        set_disp(1'b1, 8'hEE, 6'd9, 1'b1, 6'd9, 1'b1, 6'd9);
        chk("full_free_count", 32'(free_count), 32'd0);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        step();
        set_disp(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        iss_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            chk("order_valid", 32'(iss_valid),    32'd1);
            chk("order_dest",  32'(iss_dest_tag), 32'(i));
            step();
        end
        iss_ready = 1'b0;
        chk("drained_valid", 32'(iss_valid),  32'd0);
        chk("drained_free",  32'(free_count), 32'd8);

        // CDB wakeup latency
        set_disp(1'b1, 8'h33, 6'd5, 1'b0, 6'd1, 1'b1, 6'd20);
        step();
        set_disp(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        chk("wake_before", 32'(iss_valid), 32'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd5;
        #1;
`ifdef RS_WAKEUP_BYPASS_EN
        chk("wake_same_cycle", 32'(iss_valid), 32'd1);
`else
        chk("wake_same_cycle", 32'(iss_valid), 32'd0);
`endif
        step();
        cdb_valid = 1'b0;
        chk("wake_next_valid", 32'(iss_valid),    32'd1);
        chk("wake_next_dest",  32'(iss_dest_tag), 32'd20);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;

        // CDB capture in the dispatch cycle
        set_disp(1'b1, 8'h44, 6'd9, 1'b0, 6'd3, 1'b1, 6'd21);
        cdb_valid = 1'b1;
        cdb_tag   = 6'd9;
        step();
        set_disp(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        cdb_valid = 1'b0;
        chk("capture_valid", 32'(iss_valid),    32'd1);
        chk("capture_dest",  32'(iss_dest_tag), 32'd21);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;

        // rotation: slots 0..6, only 2 and 6 ready; rotation starts at 1
        for (int i = 0; i < 7; i++) begin
            set_disp(1'b1, 8'(8'h30 + i), 6'd40, (i == 2 || i == 6), 6'd7, 1'b1, 6'(30 + i));
            step();
        end
        set_disp(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        chk("rot_first", 32'(iss_dest_tag), 32'd32);
        iss_ready = 1'b1;
        step();
        iss_ready = 1'b0;
        set_disp(1'b1, 8'h55, 6'd1, 1'b1, 6'd1, 1'b1, 6'd42);
        step();
        set_disp(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        chk("rot_sel3_grant", 32'(iss_dest_tag), 32'd36);
        iss_ready = 1'b1;
        step();
        chk("rot_wrap_grant", 32'(iss_dest_tag), 32'd42);
        step();
        iss_ready = 1'b0;
        cdb_valid = 1'b1;
        cdb_tag   = 6'd40;
        step();
        cdb_valid = 1'b0;
        iss_ready = 1'b1;
        repeat (5) step();
        iss_ready = 1'b0;
        chk("rot_drained", 32'(iss_valid), 32'd0);

        // full station with simultaneous dispatch and issue
        for (int i = 0; i < N; i++) begin
            set_disp(1'b1, 8'(8'h50 + i), 6'd11, 1'b1, 6'd12, 1'b1, 6'(50 + i));
            step();
        end
        set_disp(1'b1, 8'h60, 6'd13, 1'b1, 6'd14, 1'b1, 6'd60);
        iss_ready = 1'b1;
        chk("sim_full_free",  32'(free_count), 32'd0);
        chk("sim_full_ready", 32'(disp_ready), 32'd0);
        step();
        iss_ready = 1'b0;
        chk("sim_free_one",   32'(free_count), 32'd1);
        chk("sim_ready_one",  32'(disp_ready), 32'd1);
        step();
        set_disp(1'b0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0);
        chk("sim_accepted", 32'(free_count), 32'd0);
        iss_ready = 1'b1;
        repeat (3) step();
        iss_ready = 1'b0;

        // mid-operation reset discards everything
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_free",  32'(free_count), 32'd8);
        chk("midrst_valid", 32'(iss_valid),  32'd0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
